reg_trace: RTL
==============

REG_TRACE -- requirements
Module: reg_trace

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter STOP_ON_FULL, default 0; 1 = halt capture when FIFO fills, 0 = keep capturing and drop excess.
REQ-003 clk_1Hz  input  1  clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  arms capture; sampled in IDLE only.
REQ-006 q_in  input  4  register output value being traced.
REQ-007 rd_en  input  1  pop request.
REQ-008 rd_data  output  4  popped value; registered.
REQ-009 rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-010 empty  output  1  FIFO holds 0 entries.
REQ-011 full  output  1  FIFO holds DEPTH entries.
REQ-012 count  output  clog2(DEPTH)+1  entries held (3 bits at DEPTH=4).
REQ-013 overflow  output  1  sticky: a change was dropped.
REQ-014 chg_cnt  output  8  changes detected since reset, saturating.
REQ-015 state  output  2  FSM state: IDLE=00, ARM=01, CAPTURE=10, HALT=11.

Function
REQ-016 IDLE: start=1 -> ARM next edge; no pushes.
REQ-017 ARM: baseline prev <= q_in; no push; -> CAPTURE unconditionally next edge.
REQ-018 CAPTURE: change = (q_in != prev); prev <= q_in every edge.
REQ-019 CAPTURE, change, (!full or pop this edge): push q_in at tail.
REQ-020 CAPTURE, change, full, no pop: q_in dropped; overflow <= 1.
REQ-021 chg_cnt SHALL increment on every detected change, pushed or dropped; holds at 255.
REQ-022 STOP_ON_FULL=1: a push that makes count == DEPTH SHALL move CAPTURE -> HALT on the same edge.
REQ-023 In HALT, changes SHALL be ignored: no push, chg_cnt and overflow unchanged.
REQ-024 HALT -> IDLE on the edge where count becomes 0.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 Pop: rd_en=1 and !empty -> head moves to rd_data, rd_valid=1 for one cycle (1-cycle latency).
REQ-027 rd_en=1 while empty SHALL be ignored: rd_valid=0, rd_data holds.
REQ-028 Push and pop on the same edge: when full, both SHALL proceed with count unchanged and no overflow; when empty, push proceeds and pop is ignored.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO.
REQ-030 empty = (count==0); full = (count==DEPTH); both derived from registered count.
REQ-031 Reads SHALL be permitted in every state.

Reset
REQ-032 clr=1 SHALL immediately force: state=IDLE, count=0, empty=1, full=0, pointers=0, rd_data=0, rd_valid=0, overflow=0, chg_cnt=0, prev=0.
REQ-033 clr asserted mid-capture or mid-pop SHALL discard all FIFO contents; FIFO storage need not be cleared.
REQ-034 After clr deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-035 Basic: clr, start, q_in 3,3,5,5,9,2 -> FIFO holds 5,9,2; chg_cnt=3; pops return 5,9,2 in order, rd_valid one cycle each, then empty=1.
REQ-036 Overflow (STOP_ON_FULL=0): 6 changes 1..6 after baseline 0, no reads -> full=1, count=4, contents 1,2,3,4, overflow=1, chg_cnt=6.
REQ-037 Halt (STOP_ON_FULL=1): 4 changes -> state=11 on the edge of the 4th push; further changes leave chg_cnt=4; 4 pops -> state=00.
REQ-038 Simultaneous: FIFO full, change to 7 with rd_en=1 -> oldest popped, 7 pushed, count stays 4, overflow=0.
REQ-039 Empty read and async reset: rd_en while empty -> rd_valid=0. clr asserted between edges with count=3 -> count=0, state=00, chg_cnt=0 before the next edge.

Source files
------------

// File: rtl/reg_trace_if.sv
// Trace-FIFO bus: capture control, pop port and status.
interface reg_trace_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          start;
  logic [3:0]    q_in;
  logic          rd_en;
  logic [3:0]    rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    chg_cnt;
  logic [1:0]    state;

  modport master (
    output start, q_in, rd_en,
    input  rd_data, rd_valid, empty, full,
    input  count, overflow, chg_cnt, state
  );

  modport slave (
    input  start, q_in, rd_en,
    output rd_data, rd_valid, empty, full,
    output count, overflow, chg_cnt, state
  );
endinterface

// File: rtl/reg_trace.sv
// Change-trace recorder: pushes each new q_in value into a
// small FIFO while capturing; entries are popped via rd_en.
module reg_trace #(
  parameter int DEPTH        = 4,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input logic         clk_1Hz,
  input logic         clr,
  reg_trace_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM     = 2'b01,
    CAPTURE = 2'b10,
    HALT    = 2'b11
  } state_t;

  state_t        st;
  logic [3:0]    prev;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [3:0]    mem [DEPTH];
  logic [3:0]    rd_data;
  logic          rd_valid;
  logic          overflow;
  logic [7:0]    chg_cnt;
  logic          is_empty;
  logic          is_full;
  logic          change;
  logic          pop;
  logic          push;
  logic          drop;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));
  assign change   = (st == CAPTURE) && (bus.q_in != prev);
  assign pop      = bus.rd_en && !is_empty;
  // a pop frees the slot, so a full FIFO can still take the push
  assign push     = change && (!is_full || pop);
  assign drop     = change && is_full && !pop;
  assign cnt_nxt  = cnt + CW'(push) - CW'(pop);

  always_ff @(posedge clk_1Hz or posedge clr) begin
    if (clr) begin
      st       <= IDLE;
      prev     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
      chg_cnt  <= '0;
    end else begin
      rd_valid <= pop;
      cnt      <= cnt_nxt;
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
      if (change && chg_cnt != 8'hFF)
        chg_cnt <= chg_cnt + 8'd1;
      unique case (st)
        IDLE:
          if (bus.start)
            st <= ARM;
        ARM: begin
          prev <= bus.q_in;
          st   <= CAPTURE;
        end
        CAPTURE: begin
          prev <= bus.q_in;
          if (STOP_ON_FULL && push &&
              cnt_nxt == CW'(DEPTH))
            st <= HALT;
        end
        HALT:
          if (cnt_nxt == '0)
            st <= IDLE;
        default:
          st <= IDLE;
      endcase
    end
  end

  // storage is left uncleared; pointers and count define content
  always_ff @(posedge clk_1Hz) begin
    if (push)
      mem[wr_ptr] <= bus.q_in;
  end

  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.count    = cnt;
  assign bus.overflow = overflow;
  assign bus.chg_cnt  = chg_cnt;
  assign bus.state    = st;
endmodule
